mem_port_master: RTL and testbench

// - Initiator for one port of the dual-port byte-addressed data RAM: accepts load/store requests from the core over valid/ready.
// - Drives RAM en/we/addr/wdata and returns sign- or zero-extended load data, or a store completion.
// - Faults out-of-range, misaligned and illegal-size requests without touching the RAM.
// - Sits between the core's memory stage and one RAM port, wired as that port's ram_interface master.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_load_ext.sv | 20 ++
 rtl/mem_port_master.sv | 120 ++++++++++++
 tb/tb_mem_port_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-RAM port master and its load path.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_ILL  = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } mpm_state_e;

  function automatic logic [3:0] size_to_we(mem_size_e size);
    case (size)
      MEM_BYTE: return 4'b0001;
      MEM_HALF: return 4'b0011;
      MEM_WORD: return 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

  // Illegal size reports 4 so the range check stays meaningful; it faults anyway.
  function automatic logic [2:0] size_to_nbytes(mem_size_e size);
    case (size)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load-data extender: selects byte/half/word from the RAM word and extends it.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  mem_size_e   size,
  input  logic        zero_ext,
  output logic [31:0] data
);

  always_comb begin
    data = rdata;
    case (size)
      MEM_BYTE: data = zero_ext ? {24'b0, rdata[7:0]}  : {{24{rdata[7]}}, rdata[7:0]};
      MEM_HALF: data = zero_ext ? {16'b0, rdata[15:0]} : {{16{rdata[15]}}, rdata[15:0]};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_port_master.sv
// Load/store initiator for one data-RAM port: checks requests, drives the RAM, returns extended data.
module mem_port_master
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned DATA_DEPTH       = 8192,
  parameter int unsigned ALLOW_MISALIGNED = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_fault_o,
  output logic                  rsp_misalign_o,
  output logic                  ram_en_o,
  output logic [3:0]            ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(DATA_DEPTH);

  mpm_state_e            state, state_next;
  logic                  req_we_q;
  mem_size_e             req_size_q;
  logic                  req_uns_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [31:0]           req_wdata_q;
  logic                  fault_q;
  logic                  misalign_q;
  logic [31:0]           rdata_q;

  mem_size_e             size_in;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  fault_now;
  logic                  misalign_now;
  logic                  accept;
  logic [31:0]           ext_data;

  // One extra address bit keeps addr+nbytes from wrapping near the top of the space.
  always_comb begin
    size_in      = mem_size_e'(req_size_i);
    end_addr     = {1'b0, req_addr_i} + (ADDR_WIDTH+1)'(size_to_nbytes(size_in));
    fault_now    = (size_in == MEM_ILL) || (end_addr > DEPTH);
    misalign_now = (ALLOW_MISALIGNED == 0) &&
                   (((size_in == MEM_HALF) && req_addr_i[0]) ||
                    ((size_in == MEM_WORD) && (req_addr_i[1:0] != 2'b00)));
    accept       = req_valid_i && req_ready_o;
  end

  mem_load_ext u_load_ext (
    .rdata    (ram_rdata_i),
    .size     (req_size_q),
    .zero_ext (req_uns_q),
    .data     (ext_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (fault_now || misalign_now) ? RESP : ACCESS;
      ACCESS:  state_next = req_we_q ? RESP : CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_we_q    <= 1'b0;
      req_size_q  <= MEM_BYTE;
      req_uns_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      fault_q     <= 1'b0;
      misalign_q  <= 1'b0;
      rdata_q     <= '0;
    end else if (accept) begin
      req_we_q    <= req_we_i;
      req_size_q  <= size_in;
      req_uns_q   <= req_unsigned_i;
      req_addr_q  <= req_addr_i;
      req_wdata_q <= req_wdata_i;
      fault_q     <= fault_now;
      misalign_q  <= misalign_now;
      rdata_q     <= '0;
    end else if (state == CAPTURE) begin
      rdata_q     <= ext_data;
    end
  end

  // RAM strobes are qualified by reset so an interrupted ACCESS commits nothing.
  always_comb begin
    req_ready_o    = (state == IDLE) && !rst_i;
    rsp_valid_o    = (state == RESP);
    rsp_rdata_o    = (state == RESP) ? rdata_q : '0;
    rsp_fault_o    = (state == RESP) && fault_q;
    rsp_misalign_o = (state == RESP) && misalign_q;
    ram_en_o       = (state == ACCESS) && !rst_i;
    ram_we_o       = (ram_en_o && req_we_q) ? size_to_we(req_size_q) : '0;
    ram_addr_o     = req_addr_q;
    ram_wdata_o    = req_wdata_q;
  end

endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master: two instances (aligned-only and misaligned-allowed), each with a RAM model.
module tb_mem_port_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        rsp_ready [2];
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_fault [2];
  logic        rsp_mis   [2];
  logic        ram_en    [2];
  logic [3:0]  ram_we    [2];
  logic [31:0] ram_addr  [2];
  logic [31:0] ram_wdata [2];
  logic [31:0] ram_rdata [2];

  always #5 clk = ~clk;

  mem_port_master #(.ADDR_WIDTH(32), .DATA_DEPTH(8192), .ALLOW_MISALIGNED(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
    .rsp_fault_o(rsp_fault[0]), .rsp_misalign_o(rsp_mis[0]),
    .ram_en_o(ram_en[0]), .ram_we_o(ram_we[0]), .ram_addr_o(ram_addr[0]),
    .ram_wdata_o(ram_wdata[0]), .ram_rdata_i(ram_rdata[0])
  );

  mem_port_master #(.ADDR_WIDTH(32), .DATA_DEPTH(8192), .ALLOW_MISALIGNED(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
    .rsp_fault_o(rsp_fault[1]), .rsp_misalign_o(rsp_mis[1]),
    .ram_en_o(ram_en[1]), .ram_we_o(ram_we[1]), .ram_addr_o(ram_addr[1]),
    .ram_wdata_o(ram_wdata[1]), .ram_rdata_i(ram_rdata[1])
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic string nm(input int i, input string s);
    return $sformatf("dut%0d.%s", i, s);
  endfunction

  // RAM models: synchronous read of four bytes at addr, byte-masked write.
  logic [7:0] ram [2][8192];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_en[i]) begin
        ram_rdata[i] <= {ram[i][(ram_addr[i] + 32'd3) % 8192], ram[i][(ram_addr[i] + 32'd2) % 8192],
                         ram[i][(ram_addr[i] + 32'd1) % 8192], ram[i][ram_addr[i] % 8192]};
        for (int k = 0; k < 4; k++)
          if (ram_we[i][k]) ram[i][(ram_addr[i] + 32'(k)) % 8192] = ram_wdata[i][8*k +: 8];
      end
    end
  end

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // Transaction-level model: one outstanding request per instance, scheduled by cycle number.
  bit          allow [2] = '{1'b0, 1'b1};
  logic [7:0]  ref_mem [2][8192];
  bit          pending [2] = '{1'b0, 1'b0};
  int          m_acc [2], m_due [2];
  bit          m_we [2], m_uns [2], m_legal [2], m_fault [2], m_mis [2];
  logic [1:0]  m_size [2];
  logic [31:0] m_addr [2], m_wdata [2], m_rdata [2];

  int          n, nb;
  longint      endp;
  bit          pend0, x_ready, x_en, x_valid;
  logic [31:0] val;

  always @(negedge clk) begin
    n = ecnt;
    for (int i = 0; i < 2; i++) begin
      pend0   = pending[i];
      x_ready = !pend0 && !rst;
      x_en    = pend0 && m_legal[i] && (n == m_acc[i]) && !rst;
      x_valid = pend0 && (n >= m_due[i]);
      nb      = 1 << m_size[i];
      chk(nm(i, "req_ready"), 32'(req_ready[i]), 32'(x_ready));
      chk(nm(i, "ram_en"),    32'(ram_en[i]),    32'(x_en));
      chk(nm(i, "ram_we"),    32'(ram_we[i]),    (x_en && m_we[i]) ? 32'((1 << nb) - 1) : 32'd0);
      if (x_en) begin
        chk(nm(i, "ram_addr"), ram_addr[i], m_addr[i]);
        if (m_we[i]) chk(nm(i, "ram_wdata"), ram_wdata[i], m_wdata[i]);
      end
      if (!rst) begin
        chk(nm(i, "rsp_valid"), 32'(rsp_valid[i]), 32'(x_valid));
        if (x_valid) begin
          chk(nm(i, "rsp_rdata"),    rsp_rdata[i],      m_rdata[i]);
          chk(nm(i, "rsp_fault"),    32'(rsp_fault[i]), 32'(m_fault[i]));
          chk(nm(i, "rsp_misalign"), 32'(rsp_mis[i]),   32'(m_mis[i]));
        end
      end
      if (rst) pending[i] = 1'b0;
      else begin
        if (x_en) begin
          if (m_we[i]) begin
            for (int k = 0; k < nb; k++) ref_mem[i][(m_addr[i] + 32'(k)) % 8192] = m_wdata[i][8*k +: 8];
          end else begin
            val = '0;
            for (int k = 0; k < nb; k++) val = val | (32'(ref_mem[i][(m_addr[i] + 32'(k)) % 8192]) << (8*k));
            if (nb < 4 && !m_uns[i] && val[8*nb-1]) val = val | ~((32'd1 << (8*nb)) - 32'd1);
            m_rdata[i] = val;
          end
        end
        if (x_valid && rsp_ready[i]) pending[i] = 1'b0;
        if (x_ready && req_valid[i]) begin
          m_we[i]    = req_we;
          m_size[i]  = req_size;
          m_uns[i]   = req_uns;
          m_addr[i]  = req_addr;
          m_wdata[i] = req_wdata;
          endp       = longint'(req_addr) + longint'(1 << req_size);
          m_fault[i] = (req_size == 2'd3) || (endp > 8192);
          m_mis[i]   = !allow[i] && (((req_size == 2'd1) && (req_addr % 2 != 0)) ||
                                     ((req_size == 2'd2) && (req_addr % 4 != 0)));
          m_legal[i] = !m_fault[i] && !m_mis[i];
          m_rdata[i] = '0;
          m_acc[i]   = n + 1;
          m_due[i]   = n + (!m_legal[i] ? 1 : (req_we ? 2 : 3));
          pending[i] = 1'b1;
        end
      end
    end
  end

  // Drives one request, observes the ACCESS cycle and the response, then consumes it after `hold` stall cycles.
  task automatic xfer(input int i, input bit we, input logic [1:0] size, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                      output logic [31:0] rd, output logic f, output logic m, output int lat,
                      output logic a_en, output logic [3:0] a_we, output logic [31:0] a_addr);
    int b;
    @(posedge clk); #1;
    req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
    req_valid[i] = 1'b1;
    b = 0;
    @(negedge clk);
    while (!req_ready[i] && b < 20) begin @(negedge clk); b++; end
    chk(nm(i, "accept_within_budget"), 32'(req_ready[i]), 32'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    lat = 0;
    a_en = 1'b0; a_we = '0; a_addr = '0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin a_en = ram_en[i]; a_we = ram_we[i]; a_addr = ram_addr[i]; end
    end while (!rsp_valid[i] && lat < 20);
    rd = rsp_rdata[i]; f = rsp_fault[i]; m = rsp_mis[i];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk(nm(i, "hold_rsp_valid"), 32'(rsp_valid[i]), 32'd1);
      chk(nm(i, "hold_req_ready"), 32'(req_ready[i]), 32'd0);
    end
    @(posedge clk); #1 rsp_ready[i] = 1'b1;
    @(posedge clk); #1 rsp_ready[i] = 1'b0;
  endtask

  task automatic tx(input string name, input int i, input bit we, input logic [1:0] size, input bit uns,
                    input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                    input logic [31:0] e_rd, input bit e_f, input bit e_m, input int e_lat,
                    input bit e_en, input logic [3:0] e_we);
    logic [31:0] rd, a_addr;
    logic        f, m, a_en;
    logic [3:0]  a_we;
    int          lat;
    xfer(i, we, size, uns, addr, wdata, hold, rd, f, m, lat, a_en, a_we, a_addr);
    chk({name, ".rdata"},    rd,        e_rd);
    chk({name, ".fault"},    32'(f),    32'(e_f));
    chk({name, ".misalign"}, 32'(m),    32'(e_m));
    chk({name, ".latency"},  32'(lat),  32'(e_lat));
    chk({name, ".ram_en"},   32'(a_en), 32'(e_en));
    chk({name, ".ram_we"},   32'(a_we), 32'(e_we));
    if (e_en) chk({name, ".ram_addr"}, a_addr, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 8192; a++) begin
        ram[i][a]     = 8'(a) ^ 8'h5A;
        ref_mem[i][a] = 8'(a) ^ 8'h5A;
      end
    for (int i = 0; i < 2; i++) begin req_valid[i] = 1'b0; rsp_ready[i] = 1'b0; end
    req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0; req_addr = '0; req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.req_ready", 32'(req_ready[0]), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset.req_ready", 32'(req_ready[0]), 32'd1);
    chk("post_reset.rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("post_reset.rsp_rdata", rsp_rdata[0], 32'd0);
    chk("post_reset.ram_en",    32'(ram_en[0]), 32'd0);
    chk("post_reset.ram_addr",  ram_addr[0], 32'd0);

    tx("sw_word",  0, 1, 2'd2, 0, 32'h100,  32'hDEADBEEF, 0, 32'h0,        0, 0, 2, 1, 4'hF);
    tx("lw_word",  0, 0, 2'd2, 0, 32'h100,  32'h0,        0, 32'hDEADBEEF, 0, 0, 3, 1, 4'h0);
    tx("sb_byte",  0, 1, 2'd0, 0, 32'h101,  32'h00000080, 0, 32'h0,        0, 0, 2, 1, 4'h1);
    tx("lb_sext",  0, 0, 2'd0, 0, 32'h101,  32'h0,        0, 32'hFFFFFF80, 0, 0, 3, 1, 4'h0);
    tx("lbu_zext", 0, 0, 2'd0, 1, 32'h101,  32'h0,        0, 32'h00000080, 0, 0, 3, 1, 4'h0);
    tx("lw_merge", 0, 0, 2'd2, 0, 32'h100,  32'h0,        0, 32'hDEAD80EF, 0, 0, 3, 1, 4'h0);
    tx("lh_range", 0, 0, 2'd1, 0, 32'h1FFF, 32'h0,        0, 32'h0,        1, 1, 1, 0, 4'h0);
    tx("lw_top",   0, 0, 2'd2, 0, 32'h1FFC, 32'h0,        0, 32'hA5A4A7A6, 0, 0, 3, 1, 4'h0);
    tx("ill_size", 0, 0, 2'd3, 0, 32'h0,    32'h0,        0, 32'h0,        1, 0, 1, 0, 4'h0);
    tx("lw_mis",   0, 0, 2'd2, 0, 32'h102,  32'h0,        0, 32'h0,        0, 1, 1, 0, 4'h0);
    tx("sh_half",  0, 1, 2'd1, 0, 32'h300,  32'hCAFE1234, 0, 32'h0,        0, 0, 2, 1, 4'h3);
    tx("lw_half",  0, 0, 2'd2, 0, 32'h300,  32'h0,        0, 32'h59581234, 0, 0, 3, 1, 4'h0);
    tx("lh_bp",    0, 0, 2'd1, 0, 32'h100,  32'h0,        5, 32'hFFFF80EF, 0, 0, 3, 1, 4'h0);
    @(negedge clk);
    chk("bp_release.req_ready", 32'(req_ready[0]), 32'd1);
    tx("lhu_zext", 0, 0, 2'd1, 1, 32'h100,  32'h0,        0, 32'h000080EF, 0, 0, 3, 1, 4'h0);
    tx("lw_mis_ok", 1, 0, 2'd2, 0, 32'h102, 32'h0,        0, 32'h5F5E5958, 0, 0, 3, 1, 4'h0);

    // Reset lands during the ACCESS cycle of a store.
    @(posedge clk); #1;
    req_we = 1'b1; req_size = 2'd2; req_uns = 1'b0; req_addr = 32'h200; req_wdata = 32'h11223344;
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("rst_sw.accept", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_sw.ram_we", 32'(ram_we[0]), 32'd0);
    chk("rst_sw.ram_en", 32'(ram_en[0]), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_sw.rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_sw.rsp_rdata", rsp_rdata[0], 32'd0);
    chk("rst_sw.ram_addr",  ram_addr[0], 32'd0);
    chk("rst_sw.ram_wdata", ram_wdata[0], 32'd0);
    chk("rst_sw.req_ready", 32'(req_ready[0]), 32'd1);
    tx("lw_after_rst", 0, 0, 2'd2, 0, 32'h200, 32'h0, 0, 32'h59585B5A, 0, 0, 3, 1, 4'h0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
